// File: rtl/alu_pkg.sv
// Shared definitions for the opcode ALU and its built-in self-test controller:
// opcode encodings, BIST state encoding and the LFSR feedback taps.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_CHECK = 2'b10,
        ST_DONE  = 2'b11
    } bist_state_t;

    // Taps for x^16+x^14+x^13+x^11+1: state bits 15, 13, 12 and 10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/alu_bist_ctrl_if.sv
// Signal bundle between the BIST controller (master) and the ALU/host side (slave).
interface alu_bist_ctrl_if #(
    parameter int N = 4
);
    logic         start;
    logic [N-1:0] in0;
    logic [N-1:0] in1;
    logic [N-1:0] alu_out;
    logic         busy;
    logic         done;
    logic         pass;
    logic [7:0]   err_count;
    logic [7:0]   fail_idx;
    logic [N-1:0] fail_exp;
    logic [N-1:0] fail_act;

    modport master (
        input  start, alu_out,
        output in0, in1, busy, done, pass, err_count, fail_idx, fail_exp, fail_act
    );

    modport slave (
        output start, alu_out,
        input  in0, in1, busy, done, pass, err_count, fail_idx, fail_exp, fail_act
    );
endinterface

// File: rtl/bist_lfsr16.sv
// 16-bit Fibonacci LFSR operand generator with synchronous load of the seed.
module bist_lfsr16
    import alu_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_en,
    output logic [15:0] o_state
);
    logic [15:0] r_state;
    logic        w_fb;

    assign w_fb = ^(r_state & LFSR_TAPS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= SEED;
        else if (i_load)
            r_state <= SEED;
        else if (i_en)
            r_state <= {r_state[14:0], w_fb};
    end

    assign o_state = r_state;
endmodule

// File: rtl/alu_bist_ctrl.sv
// Hardware self-test for one ALU instance: drives LFSR operands, checks each
// result against a golden model and reports error count and first failure.
module alu_bist_ctrl
    import alu_pkg::*;
#(
    parameter int          N           = 4,
    parameter logic [1:0]  OPCODE      = OP_ADD,
    parameter int          NUM_VECTORS = 10,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    alu_bist_ctrl_if.master bus
);
    localparam logic [7:0] LAST_IDX = 8'(NUM_VECTORS - 1);

    bist_state_t  r_state;
    bist_state_t  w_next;
    logic         w_load;
    logic         w_adv;
    logic         w_busy;
    logic         w_done;
    logic [15:0]  w_lfsr;
    logic         w_unused_lfsr;
    logic [N-1:0] w_in0;
    logic [N-1:0] w_in1;
    logic [N-1:0] w_golden;
    logic         w_mismatch;
    logic [7:0]   r_vec_idx;
    logic [7:0]   r_err_count;
    logic [7:0]   r_fail_idx;
    logic [N-1:0] r_fail_exp;
    logic [N-1:0] r_fail_act;

    bist_lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_en    (w_adv),
        .o_state (w_lfsr)
    );

    assign w_in0         = w_lfsr[N-1:0];
    assign w_in1         = w_lfsr[15 -: N];
    assign w_unused_lfsr = ^w_lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // A start in DONE re-arms exactly like one in IDLE; DRIVE/CHECK never look at start.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_adv  = 1'b0;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_load = 1'b1;
                    w_next = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                w_busy = 1'b1;
                w_next = ST_CHECK;
            end
            ST_CHECK: begin
                w_busy = 1'b1;
                w_adv  = 1'b1;
                w_next = (r_vec_idx == LAST_IDX) ? ST_DONE : ST_DRIVE;
            end
            ST_DONE: begin
                w_done = 1'b1;
                if (bus.start) begin
                    w_load = 1'b1;
                    w_next = ST_DRIVE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_golden = '0;
        case (OPCODE)
            OP_ADD:  w_golden = w_in0 + w_in1;
            OP_OR:   w_golden = w_in0 | w_in1;
            OP_SUB:  w_golden = w_in0 - w_in1;
            OP_XOR:  w_golden = w_in0 ^ w_in1;
            default: w_golden = '0;
        endcase
    end

    assign w_mismatch = (bus.alu_out != w_golden);

    // An error count of zero marks the first mismatch, since the count never wraps back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec_idx   <= '0;
            r_err_count <= '0;
            r_fail_idx  <= '0;
            r_fail_exp  <= '0;
            r_fail_act  <= '0;
        end else if (w_load) begin
            r_vec_idx   <= '0;
            r_err_count <= '0;
            r_fail_idx  <= '0;
            r_fail_exp  <= '0;
            r_fail_act  <= '0;
        end else if (r_state == ST_CHECK) begin
            if (w_mismatch) begin
                if (r_err_count != 8'hFF)
                    r_err_count <= r_err_count + 8'd1;
                if (r_err_count == 8'd0) begin
                    r_fail_idx <= r_vec_idx;
                    r_fail_exp <= w_golden;
                    r_fail_act <= bus.alu_out;
                end
            end
            if (r_vec_idx != LAST_IDX)
                r_vec_idx <= r_vec_idx + 8'd1;
        end
    end

    assign bus.in0       = w_in0;
    assign bus.in1       = w_in1;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.pass      = w_done && (r_err_count == 8'd0);
    assign bus.err_count = r_err_count;
    assign bus.fail_idx  = r_fail_idx;
    assign bus.fail_exp  = r_fail_exp;
    assign bus.fail_act  = r_fail_act;
endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Directed bench for alu_bist_ctrl: five N=4 instances (XOR, ADD, OR, SUB, and XOR
// with a stuck ALU output) checked against hand-computed LFSR operands and reports.
module tb_alu_bist_ctrl;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic subCorrupt = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Operands for vectors 0..9 from SEED 16'hACE1: in0 = lfsr[3:0], in1 = lfsr[15:12].
    logic [3:0] expIn0 [0:9] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};
    logic [3:0] expIn1 [0:9] = '{4'hA, 4'h5, 4'hB, 4'h6, 4'hC, 4'h9, 4'h3, 4'h7, 4'hE, 4'hC};

    always #5 clk = ~clk;

    alu_bist_ctrl_if #(.N(4)) busXor ();
    alu_bist_ctrl_if #(.N(4)) busAdd ();
    alu_bist_ctrl_if #(.N(4)) busOr ();
    alu_bist_ctrl_if #(.N(4)) busSub ();
    alu_bist_ctrl_if #(.N(4)) busTied ();

    // Behavioural ALUs; the SUB one can be corrupted on every vector whose in0 is not 1.
    assign busXor.alu_out  = busXor.in0 ^ busXor.in1;
    assign busAdd.alu_out  = busAdd.in0 + busAdd.in1;
    assign busOr.alu_out   = busOr.in0 | busOr.in1;
    assign busSub.alu_out  = (subCorrupt && busSub.in0 != 4'h1) ? 4'h0 : busSub.in0 - busSub.in1;
    assign busTied.alu_out = 4'hB;

    alu_bist_ctrl #(.N(4), .OPCODE(OP_XOR), .NUM_VECTORS(10), .SEED(16'hACE1)) uXor (
        .clk(clk), .rst(rst), .bus(busXor));
    alu_bist_ctrl #(.N(4), .OPCODE(OP_ADD), .NUM_VECTORS(10), .SEED(16'hACE1)) uAdd (
        .clk(clk), .rst(rst), .bus(busAdd));
    alu_bist_ctrl #(.N(4), .OPCODE(OP_OR), .NUM_VECTORS(10), .SEED(16'hACE1)) uOr (
        .clk(clk), .rst(rst), .bus(busOr));
    alu_bist_ctrl #(.N(4), .OPCODE(OP_SUB), .NUM_VECTORS(10), .SEED(16'hACE1)) uSub (
        .clk(clk), .rst(rst), .bus(busSub));
    alu_bist_ctrl #(.N(4), .OPCODE(OP_XOR), .NUM_VECTORS(10), .SEED(16'hACE1)) uTied (
        .clk(clk), .rst(rst), .bus(busTied));

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busXor.in0 !== 4'h1) begin errors++; $display("[TB] FAIL reset_in0 got %h want %h", busXor.in0, 4'h1); end
        checks++; if (busXor.in1 !== 4'hA) begin errors++; $display("[TB] FAIL reset_in1 got %h want %h", busXor.in1, 4'hA); end
        checks++; if ({busXor.busy, busXor.done, busXor.pass} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got %b want 000", {busXor.busy, busXor.done, busXor.pass}); end
        checks++; if ({busXor.err_count, busXor.fail_idx, busXor.fail_exp, busXor.fail_act} !== 24'h0) begin errors++; $display("[TB] FAIL reset_report got %h want 000000", {busXor.err_count, busXor.fail_idx, busXor.fail_exp, busXor.fail_act}); end
    endtask

    task automatic test_xor_run;
        int edges;
        @(negedge clk);
        busXor.start = 1'b1;
        @(posedge clk);
        #1 busXor.start = 1'b0;
        edges = 0;
        checks++; if ({busXor.in0, busXor.in1} !== {expIn0[0], expIn1[0]}) begin errors++; $display("[TB] FAIL xor_vec0 got %h want %h", {busXor.in0, busXor.in1}, {expIn0[0], expIn1[0]}); end
        checks++; if (busXor.busy !== 1'b1) begin errors++; $display("[TB] FAIL xor_busy got %b want 1", busXor.busy); end
        while (busXor.done !== 1'b1 && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges % 2 == 0 && edges < 20) begin
                checks++; if ({busXor.in0, busXor.in1} !== {expIn0[edges/2], expIn1[edges/2]}) begin errors++; $display("[TB] FAIL xor_vec%0d got %h want %h", edges/2, {busXor.in0, busXor.in1}, {expIn0[edges/2], expIn1[edges/2]}); end
            end
        end
        checks++; if (edges != 20) begin errors++; $display("[TB] FAIL xor_latency got %0d want 20", edges); end
        checks++; if (busXor.pass !== 1'b1) begin errors++; $display("[TB] FAIL xor_pass got %b want 1", busXor.pass); end
        checks++; if (busXor.err_count !== 8'd0) begin errors++; $display("[TB] FAIL xor_err got %0d want 0", busXor.err_count); end
        checks++; if (busXor.busy !== 1'b0) begin errors++; $display("[TB] FAIL xor_busy_done got %b want 0", busXor.busy); end
    endtask

    // Restart from DONE, with a stray start during the first CHECK that must be ignored.
    task automatic test_restart;
        int edges;
        @(negedge clk);
        busXor.start = 1'b1;
        @(posedge clk);
        #1 busXor.start = 1'b0;
        checks++; if ({busXor.done, busXor.busy} !== 2'b01) begin errors++; $display("[TB] FAIL restart_flags got %b want 01", {busXor.done, busXor.busy}); end
        checks++; if ({busXor.in0, busXor.in1} !== {expIn0[0], expIn1[0]}) begin errors++; $display("[TB] FAIL restart_vec0 got %h want %h", {busXor.in0, busXor.in1}, {expIn0[0], expIn1[0]}); end
        @(posedge clk);
        #1 busXor.start = 1'b1;
        @(posedge clk);
        #1 busXor.start = 1'b0;
        edges = 2;
        checks++; if ({busXor.in0, busXor.in1} !== {expIn0[1], expIn1[1]}) begin errors++; $display("[TB] FAIL restart_vec1 got %h want %h", {busXor.in0, busXor.in1}, {expIn0[1], expIn1[1]}); end
        while (busXor.done !== 1'b1 && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges % 2 == 0 && edges < 20) begin
                checks++; if ({busXor.in0, busXor.in1} !== {expIn0[edges/2], expIn1[edges/2]}) begin errors++; $display("[TB] FAIL restart_vec%0d got %h want %h", edges/2, {busXor.in0, busXor.in1}, {expIn0[edges/2], expIn1[edges/2]}); end
            end
        end
        checks++; if (edges != 20) begin errors++; $display("[TB] FAIL restart_latency got %0d want 20", edges); end
        checks++; if ({busXor.pass, busXor.err_count} !== 9'h100) begin errors++; $display("[TB] FAIL restart_result got %h want 100", {busXor.pass, busXor.err_count}); end
    endtask

    task automatic test_ops;
        int edges;
        @(negedge clk);
        busAdd.start = 1'b1;
        busOr.start  = 1'b1;
        busSub.start = 1'b1;
        @(posedge clk);
        #1;
        busAdd.start = 1'b0;
        busOr.start  = 1'b0;
        busSub.start = 1'b0;
        edges = 0;
        while (!(busAdd.done === 1'b1 && busOr.done === 1'b1 && busSub.done === 1'b1) && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checks++; if (edges != 20) begin errors++; $display("[TB] FAIL ops_latency got %0d want 20", edges); end
        checks++; if ({busAdd.pass, busAdd.err_count} !== 9'h100) begin errors++; $display("[TB] FAIL add_result got %h want 100", {busAdd.pass, busAdd.err_count}); end
        checks++; if ({busOr.pass, busOr.err_count} !== 9'h100) begin errors++; $display("[TB] FAIL or_result got %h want 100", {busOr.pass, busOr.err_count}); end
        checks++; if ({busSub.pass, busSub.err_count} !== 9'h100) begin errors++; $display("[TB] FAIL sub_result got %h want 100", {busSub.pass, busSub.err_count}); end
    endtask

    // Vector 0 (1-A=7) still matches; vector 1 needs the wrapped 0011-0101=1110 golden.
    task automatic test_sub_wrap;
        int edges;
        subCorrupt = 1'b1;
        @(negedge clk);
        busSub.start = 1'b1;
        @(posedge clk);
        #1 busSub.start = 1'b0;
        edges = 0;
        while (busSub.done !== 1'b1 && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checks++; if (busSub.fail_idx !== 8'd1) begin errors++; $display("[TB] FAIL sub_fail_idx got %0d want 1", busSub.fail_idx); end
        checks++; if (busSub.fail_exp !== 4'hE) begin errors++; $display("[TB] FAIL sub_fail_exp got %b want 1110", busSub.fail_exp); end
        checks++; if (busSub.fail_act !== 4'h0) begin errors++; $display("[TB] FAIL sub_fail_act got %b want 0000", busSub.fail_act); end
        checks++; if ({busSub.done, busSub.pass, busSub.err_count} !== 10'b10_0000_1001) begin errors++; $display("[TB] FAIL sub_report got %b want 1000001001", {busSub.done, busSub.pass, busSub.err_count}); end
        subCorrupt = 1'b0;
    endtask

    task automatic test_tied;
        int edges;
        @(negedge clk);
        busTied.start = 1'b1;
        @(posedge clk);
        #1 busTied.start = 1'b0;
        edges = 0;
        while (busTied.done !== 1'b1 && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checks++; if (edges != 20) begin errors++; $display("[TB] FAIL tied_latency got %0d want 20", edges); end
        checks++; if (busTied.fail_idx !== 8'd1) begin errors++; $display("[TB] FAIL tied_fail_idx got %0d want 1", busTied.fail_idx); end
        checks++; if (busTied.fail_exp !== 4'h6) begin errors++; $display("[TB] FAIL tied_fail_exp got %b want 0110", busTied.fail_exp); end
        checks++; if (busTied.fail_act !== 4'hB) begin errors++; $display("[TB] FAIL tied_fail_act got %b want 1011", busTied.fail_act); end
        checks++; if (busTied.pass !== 1'b0) begin errors++; $display("[TB] FAIL tied_pass got %b want 0", busTied.pass); end
        checks++; if (busTied.err_count !== 8'd9) begin errors++; $display("[TB] FAIL tied_err got %0d want 9", busTied.err_count); end
    endtask

    task automatic test_reset_midrun;
        @(negedge clk);
        busXor.start  = 1'b1;
        busTied.start = 1'b1;
        @(posedge clk);
        #1;
        busXor.start  = 1'b0;
        busTied.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++; if ({busXor.in0, busXor.busy} !== {expIn0[2], 1'b1}) begin errors++; $display("[TB] FAIL mid_drive got %h want %h", {busXor.in0, busXor.busy}, {expIn0[2], 1'b1}); end
        checks++; if (busTied.err_count !== 8'd1) begin errors++; $display("[TB] FAIL mid_partial_err got %0d want 1", busTied.err_count); end
        rst = 1'b1;
        #1;
        checks++; if ({busXor.in0, busXor.in1} !== 8'h1A) begin errors++; $display("[TB] FAIL mid_rst_operands got %h want 1a", {busXor.in0, busXor.in1}); end
        checks++; if ({busXor.busy, busXor.done, busXor.pass} !== 3'b000) begin errors++; $display("[TB] FAIL mid_rst_flags got %b want 000", {busXor.busy, busXor.done, busXor.pass}); end
        checks++; if ({busTied.err_count, busTied.fail_idx, busTied.fail_exp, busTied.fail_act} !== 24'h0) begin errors++; $display("[TB] FAIL mid_rst_report got %h want 000000", {busTied.err_count, busTied.fail_idx, busTied.fail_exp, busTied.fail_act}); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({busXor.busy, busXor.done, busTied.busy, busTied.done} !== 4'b0000) begin errors++; $display("[TB] FAIL mid_idle got %b want 0000", {busXor.busy, busXor.done, busTied.busy, busTied.done}); end
    endtask

    initial begin
        busXor.start  = 1'b0;
        busAdd.start  = 1'b0;
        busOr.start   = 1'b0;
        busSub.start  = 1'b0;
        busTied.start = 1'b0;
        test_reset();
        test_xor_run();
        test_restart();
        test_ops();
        test_sub_wrap();
        test_tied();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
